// File: rtl/scope_trace_render_if.sv
// Pixel timing, ADC sample and VGA output bundle for scope_trace_render.
// The master side drives timing/ADC and observes video; the slave side is the renderer.
interface scope_trace_render_if;
   logic       VGA_CLK;
   logic [9:0] x;
   logic [8:0] y;
   logic       disp_en;
   logic       hsync_in;
   logic       vsync_in;
   logic       adc_valid;
   logic [7:0] adc_data;
   logic [7:0] trig_level;
   logic [7:0] VGA_R;
   logic [7:0] VGA_G;
   logic [7:0] VGA_B;
   logic       VGA_HS;
   logic       VGA_VS;
   logic       VGA_BLANK_N;
   logic [1:0] trig_state;

   modport master (
      output VGA_CLK, x, y, disp_en, hsync_in, vsync_in, adc_valid, adc_data, trig_level,
      input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, trig_state
   );

   modport slave (
      input  VGA_CLK, x, y, disp_en, hsync_in, vsync_in, adc_valid, adc_data, trig_level,
      output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, trig_state
   );
endinterface

// File: rtl/scope_trace_render.sv
// Rising-edge triggered capture into a double-buffered 640-sample trace, drawn as a yellow line.
// Optional background grid enabled by defining SCOPE_GRID_EN.
module scope_trace_render (
   input logic CLOCK_50,
   input logic RESET_N,
   scope_trace_render_if.slave bus
);
   localparam int unsigned Depth = 640;

   typedef enum logic [1:0] {StArm = 2'd0, StCapture = 2'd1, StDone = 2'd2} state_e;

   state_e     state;
   logic [9:0] wr_ptr;
   logic [9:0] wr_addr;
   logic       wr_en;
   logic       front_sel;
   logic       trace_valid;
   logic [7:0] prev_sample;
   logic       prev_vsync;
   logic       vsync_fall;
   logic       trig_hit;

   logic [7:0] mem0 [Depth];
   logic [7:0] mem1 [Depth];

   logic [9:0] s1_x;
   logic [8:0] s1_y;
   logic       s1_de;
   logic       s1_hs;
   logic       s1_vs;
   logic [7:0] rd_data;

   logic [7:0] vga_r, vga_g, vga_b;
   logic       vga_hs, vga_vs, vga_blank_n;

   logic [8:0] row;
   logic       trace_pix;
   logic       grid_pix;

   assign vsync_fall = prev_vsync & ~bus.vsync_in;
   assign trig_hit   = bus.adc_valid && (prev_sample < bus.trig_level) &&
                       (bus.adc_data >= bus.trig_level);

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = wr_ptr;
      case (state)
         StArm: begin
            wr_en   = trig_hit;
            wr_addr = 10'd0;
         end
         StCapture: wr_en = bus.adc_valid;
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= StArm;
         wr_ptr      <= 10'd0;
         front_sel   <= 1'b0;
         trace_valid <= 1'b0;
         prev_sample <= 8'hFF;
         prev_vsync  <= 1'b1;
      end else begin
         prev_vsync <= bus.vsync_in;
         if (bus.adc_valid) prev_sample <= bus.adc_data;
         case (state)
            StArm: begin
               if (trig_hit) begin
                  wr_ptr <= 10'd1;
                  state  <= StCapture;
               end
            end
            StCapture: begin
               if (bus.adc_valid) begin
                  if (wr_ptr == 10'd639) state <= StDone;
                  wr_ptr <= wr_ptr + 10'd1;
               end
            end
            StDone: begin
               if (vsync_fall) begin
                  front_sel   <= ~front_sel;
                  trace_valid <= 1'b1;
                  wr_ptr      <= 10'd0;
                  state       <= StArm;
               end
            end
            default: state <= StArm;
         endcase
      end
   end

   // Writes always target the buffer not being displayed.
   always_ff @(posedge CLOCK_50) begin
      if (wr_en) begin
         if (front_sel) mem0[wr_addr] <= bus.adc_data;
         else           mem1[wr_addr] <= bus.adc_data;
      end
   end

   assign row       = 9'd367 - {1'b0, rd_data};
   assign trace_pix = trace_valid && (s1_x < 10'd640) && (s1_y == row);
`ifdef SCOPE_GRID_EN
   assign grid_pix  = s1_de && ((s1_x[5:0] == 6'd0) || (s1_y[5:0] == 6'd0));
`else
   assign grid_pix  = 1'b0;
`endif

   // Sync stages reset high so the outputs idle deasserted during reset.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         s1_x        <= 10'd0;
         s1_y        <= 9'd0;
         s1_de       <= 1'b0;
         s1_hs       <= 1'b1;
         s1_vs       <= 1'b1;
         rd_data     <= 8'd0;
         vga_r       <= 8'd0;
         vga_g       <= 8'd0;
         vga_b       <= 8'd0;
         vga_blank_n <= 1'b0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
      end else if (bus.VGA_CLK) begin
         s1_x    <= bus.x;
         s1_y    <= bus.y;
         s1_de   <= bus.disp_en;
         s1_hs   <= bus.hsync_in;
         s1_vs   <= bus.vsync_in;
         rd_data <= front_sel ? mem1[bus.x] : mem0[bus.x];
         vga_hs  <= s1_hs;
         vga_vs  <= s1_vs;
         vga_blank_n <= s1_de;
         if (!s1_de) begin
            {vga_r, vga_g, vga_b} <= 24'h000000;
         end else if (trace_pix) begin
            {vga_r, vga_g, vga_b} <= 24'hFFFF00;
         end else if (grid_pix) begin
            {vga_r, vga_g, vga_b} <= 24'h404040;
         end else begin
            {vga_r, vga_g, vga_b} <= 24'h000000;
         end
      end
   end

   assign bus.VGA_R       = vga_r;
   assign bus.VGA_G       = vga_g;
   assign bus.VGA_B       = vga_b;
   assign bus.VGA_HS      = vga_hs;
   assign bus.VGA_VS      = vga_vs;
   assign bus.VGA_BLANK_N = vga_blank_n;
   assign bus.trig_state  = state;
endmodule

// File: tb/tb_scope_trace_render.sv
// Randomized scoreboard bench for scope_trace_render against a queue-based capture model.
// Grid expectations follow SCOPE_GRID_EN when it is defined for the build.
module tb_scope_trace_render;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   scope_trace_render_if bus ();

   scope_trace_render dut (
      .CLOCK_50(clk),
      .RESET_N (rst_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [26:0] pix_q[$];
   logic [1:0]  st_q[$];

   // Reference model: a trace is a list of captured samples, shown once a frame starts.
   localparam int MArm = 0, MCap = 1, MDone = 2;
   int mstate = MArm;
   int cap[$];
   int shown[640];
   bit mtv = 0;
   int mprev = 255;
   bit mpvs = 1;

   bit en = 0, de = 0, hs = 1, vs = 1, av = 0;
   int px = 0, py = 0, ad = 0, tl = 80;

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [26:0] exp_pix();
      logic [23:0] rgb;
      rgb = 24'h000000;
      if (de) begin
         if (mtv && px < 640 && py == 367 - shown[px]) rgb = 24'hFFFF00;
`ifdef SCOPE_GRID_EN
         else if (px % 64 == 0 || py % 64 == 0) rgb = 24'h404040;
`endif
      end
      return {rgb, de, hs, vs};
   endfunction

   task automatic model_step();
      bit vfall;
      vfall = mpvs && !vs;
      mpvs = vs;
      case (mstate)
         MArm: if (av && mprev < tl && ad >= tl) begin
            cap.delete();
            cap.push_back(ad);
            mstate = MCap;
         end
         MCap: if (av) begin
            cap.push_back(ad);
            if (cap.size() == 640) mstate = MDone;
         end
         default: if (vfall) begin
            foreach (shown[i]) shown[i] = cap[i];
            mtv = 1;
            mstate = MArm;
         end
      endcase
      if (av) mprev = ad;
   endtask

   task automatic model_reset();
      mstate = MArm;
      mtv = 0;
      mprev = 255;
      mpvs = 1;
      cap.delete();
   endtask

   task automatic tick();
      bus.VGA_CLK    = en;
      bus.x          = px[9:0];
      bus.y          = py[8:0];
      bus.disp_en    = de;
      bus.hsync_in   = hs;
      bus.vsync_in   = vs;
      bus.adc_valid  = av;
      bus.adc_data   = ad[7:0];
      bus.trig_level = tl[7:0];
      model_step();
      st_q.push_back(2'(mstate));
      if (en) pix_q.push_back(exp_pix());
      @(negedge clk);
      #1;
   endtask

   task automatic rand_pix(bit vrand);
      en = 1'($urandom % 2);
      px = $urandom_range(0, 799);
      de = ($urandom % 8) != 0;
      hs = 1'($urandom % 2);
      if (vrand) vs = 1'($urandom % 2);
      if (px < 640 && ($urandom % 2) == 1) py = 367 - shown[px];
      else if ($urandom % 6 == 0) py = 64 * $urandom_range(0, 8);
      else py = $urandom_range(0, 524);
   endtask

   task automatic dpix(int x_, int y_, bit de_);
      en = 1; px = x_; py = y_; de = de_;
      tick();
   endtask

   // One extra enable retires the last checked pixel; the filler itself is dropped.
   task automatic pipe_end();
      av = 0;
      en = 1;
      tick();
      pix_q.delete();
      en = 0;
   endtask

   task automatic window(int n, bit vrand);
      for (int i = 0; i < n; i++) begin
         rand_pix(vrand);
         tick();
      end
      pipe_end();
   endtask

   task automatic capture(bit with_pix, int stop_size);
      int guard;
      guard = 0;
      en = 0; vs = 1; av = 1;
      ad = 70; tick();
      ad = 90; tick();
      while (mstate == MCap && cap.size() < stop_size && guard < 20000) begin
         guard++;
         av = 1'($urandom % 2);
         ad = (cap.size() == 100) ? 128 : int'($urandom % 256);
         if (with_pix) rand_pix(0);
         tick();
      end
      if (guard >= 20000) check("capture_bound", 32'(guard), 32'(0));
      if (with_pix) pipe_end();
      av = 0; en = 0;
   endtask

   task automatic vfall_seq();
      en = 0; av = 0;
      vs = 1; tick();
      vs = 0; tick();
      vs = 1; tick();
   endtask

   task automatic reset_checks(string tag);
      check({tag, "_rgb"}, 32'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 32'(0));
      check({tag, "_blank_n"}, 32'(bus.VGA_BLANK_N), 32'(0));
      check({tag, "_hs"}, 32'(bus.VGA_HS), 32'(1));
      check({tag, "_vs"}, 32'(bus.VGA_VS), 32'(1));
      check({tag, "_trig_state"}, 32'(bus.trig_state), 32'(0));
   endtask

   always @(negedge clk) begin
      if (st_q.size() > 0) check("trig_state", 32'(bus.trig_state), 32'(st_q.pop_front()));
      if (bus.VGA_CLK === 1'b1 && pix_q.size() >= 2)
         check("pixel", 32'({bus.VGA_R, bus.VGA_G, bus.VGA_B, bus.VGA_BLANK_N, bus.VGA_HS,
                             bus.VGA_VS}), 32'(pix_q.pop_front()));
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      bus.VGA_CLK = 0; bus.x = 0; bus.y = 0; bus.disp_en = 0; bus.hsync_in = 1;
      bus.vsync_in = 1; bus.adc_valid = 0; bus.adc_data = 0; bus.trig_level = 8'd80;
      #12;
      reset_checks("reset");
      @(negedge clk);
      #1 rst_n = 1;

      // No trace yet: grid/black and blanking only.
      dpix(64, 10, 1);
      dpix(200, 300, 0);
      dpix(64, 10, 1);
      window(60, 1);

      // First capture while displaying; extra samples in DONE are ignored.
      capture(1, 640);
      av = 1;
      for (int i = 0; i < 20; i++) begin
         ad = $urandom % 256;
         tick();
      end
      av = 0;
      vfall_seq();
      dpix(100, 239, 1);
      dpix(0, 277, 1);
      dpix(100, 239, 1);
      window(200, 1);

      // Final write lands on the same clock as a vsync fall: swap deferred.
      capture(1, 639);
      av = 1; ad = 55; vs = 0; tick();
      av = 0; vs = 1; tick();
      window(100, 0);
      vfall_seq();
      window(150, 1);

      // Reset part way through a capture.
      capture(1, 300);
      rst_n = 0;
      model_reset();
      pix_q.delete();
      #3;
      reset_checks("midcap");
      @(negedge clk);
      #1 rst_n = 1;
      dpix(64, 10, 1);
      window(150, 1);
      capture(0, 640);
      vfall_seq();
      window(200, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
